sound_shared_ram: RTL and testbench
===================================

Name: sound_shared_ram

Overview:
- Parametrised shared sound RAM that sits between the main CPU 16-bit bus and the 8-bit sound CPU bus.
- Provides byte-lane RAM with fixed-priority arbitration between the two ports and registered read data on both sides.
- Main port drives a wait line; sound port drives S_WAIT_N.
- Adds a main-to-sound command latch that raises a sound-CPU interrupt.

Parameters:
AW, 15, main word-address width; RAM is 2^AW words x 16 bits (sound byte address width AW+1)
INIT_ZERO, 0, 1 = RAM contents initialised to zero at configuration (simulation/FPGA init); reset never clears RAM

Ports:
CLK_32M  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
DIN  in  16  main write data
DOUT  out  16  main read data, registered
DOUT_VALID  out  1  main read data valid
A  in  19  main address A[19:1]; A[AW:1] selects word
BYTE_SEL  in  2  main byte enables; [1]=DIN[15:8], [0]=DIN[7:0]
SDBEN  in  1  main chip select for RAM
MRD  in  1  main read strobe
MWR  in  1  main write strobe
CMD_WR  in  1  main strobe writing DIN[7:0] to command latch
S_A  in  AW+1  sound byte address
S_DIN  in  8  sound write data
S_DOUT  out  8  sound read data, registered
S_CS  in  1  sound RAM select
S_RD  in  1  sound read strobe
S_WR  in  1  sound write strobe
S_CMD_RD  in  1  sound strobe reading command latch
S_WAIT_N  out  1  sound wait, low while access not yet completed
S_IRQ_N  out  1  sound interrupt, low while command unread

Behaviour:
- Requests:
  - main_req = SDBEN & (MRD|MWR).
  - snd_req = S_CS & (S_RD|S_WR).
  - Each is rising-edge detected with registers reset to 0, so one RAM operation is performed per strobe assertion.
  - A request held through reset release is serviced once.
- Pending flags: set on request edge; cleared in the cycle the request is granted.
- Arbiter, evaluated every cycle:
  - If main pending, grant main; else if sound pending, grant sound.
  - At most one RAM operation per cycle.
  - Sound waits at most 1 extra cycle per colliding main access.
- Writes:
  - Main write writes the lanes enabled by BYTE_SEL at A[AW:1]; BYTE_SEL=00 is a no-op grant.
  - Sound write writes S_DIN into lane S_A[0] (0=low byte, 1=high byte) of word S_A[AW:1].
  - MWR takes precedence if MRD and MWR are both high.
- Reads: synchronous RAM, 1-cycle latency.
  - Main read granted in cycle N: DOUT loaded at edge N+1, DOUT_VALID=1 from N+1 until main_req deasserts; then DOUT_VALID=0 and DOUT holds its last value.
  - Sound read granted in cycle N: S_DOUT = selected byte at edge N+1.
  - Read of a word written in the previous grant cycle returns the new data (no read-during-write hazard across ports).
- S_WAIT_N:
  - Goes low combinationally with the sound request edge.
  - Returns high on the cycle S_DOUT is loaded (read) or the cycle after write grant.
  - Stays high when no sound access is pending.
- Command latch:
  - CMD_WR rising edge loads CMD=DIN[7:0] and drives S_IRQ_N low.
  - S_CMD_RD rising edge loads S_DOUT=CMD next cycle and drives S_IRQ_N high.
  - If CMD_WR and S_CMD_RD edges coincide: the write wins, S_IRQ_N stays low, and S_DOUT returns the old CMD.
  - S_CMD_RD has priority over a sound RAM read completing in the same cycle; the RAM read completes one cycle later.
- Reset values: DOUT=0, DOUT_VALID=0, S_DOUT=0, S_WAIT_N=1, S_IRQ_N=1, CMD=0, pending flags and edge registers=0.
- Reset asserted mid-access: the access is abandoned and no partial write is committed after reset asserts. RAM contents are retained.
- Address wrap: bits of A above AW are ignored, so the RAM aliases every 2^AW words.

Test Plan:
- Main write 0xBEEF to word 0x0010 with BYTE_SEL=11, then main read -> DOUT=0xBEEF, DOUT_VALID high 1 cycle after grant, drops when MRD falls.
- Main write BYTE_SEL=10 with data 0x12xx over 0xBEEF, then sound reads byte 0x0021 and 0x0020 -> S_DOUT=0x12 then 0xEF.
- Main write and sound read edges in the same cycle to the same word -> main granted first; sound sees the new data one cycle later; S_WAIT_N low exactly 2 cycles.
- CMD_WR with DIN=0x5A -> S_IRQ_N low; S_CMD_RD -> S_DOUT=0x5A, S_IRQ_N high. Coincident CMD_WR(0x33)/S_CMD_RD -> S_DOUT=0x5A, S_IRQ_N stays low, CMD=0x33.
- Assert RESET_N low during a pending sound write -> all outputs at reset values and the target byte is unchanged. MRD held across reset release -> exactly one read is serviced.
- AW=15: write at A=0x08010 (word 0x08010), read at word 0x00010 -> same data (alias).

Source files
------------

// File: rtl/sound_shared_ram.sv
// Shared sound RAM between the 16-bit main CPU bus and the 8-bit sound CPU bus.
// Fixed-priority arbitration (main first), one RAM operation per cycle,
// registered read data on both sides, plus a main-to-sound command latch
// that drives the sound CPU interrupt.
module sound_shared_ram #(
  parameter int AW        = 15,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic          CLK_32M,
  input  logic          RESET_N,
  input  logic [15:0]   DIN,
  output logic [15:0]   DOUT,
  output logic          DOUT_VALID,
  input  logic [19:1]   A,
  input  logic [1:0]    BYTE_SEL,
  input  logic          SDBEN,
  input  logic          MRD,
  input  logic          MWR,
  input  logic          CMD_WR,
  input  logic [AW:0]   S_A,
  input  logic [7:0]    S_DIN,
  output logic [7:0]    S_DOUT,
  input  logic          S_CS,
  input  logic          S_RD,
  input  logic          S_WR,
  input  logic          S_CMD_RD,
  output logic          S_WAIT_N,
  output logic          S_IRQ_N
);

  localparam int DEPTH = 1 << AW;

  // RAM storage; never touched by reset so contents survive it.
  logic [15:0] mem [0:DEPTH-1] = '{default: (INIT_ZERO ? 16'h0000 : 16'hxxxx)};

  // Upper main address bits are ignored so the RAM aliases every 2^AW words.
  logic [AW-1:0] m_word;
  logic [AW-1:0] s_word;
  logic          s_lane;
  logic          unused_addr;

  assign m_word      = A[AW:1];
  assign s_word      = S_A[AW:1];
  assign s_lane      = S_A[0];
  assign unused_addr = ^A[19:AW+1];

  // Registered state
  logic        main_req_q, main_req_d;
  logic        snd_req_q, snd_req_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic        cmd_rd_q, cmd_rd_d;
  logic        main_pend_q, main_pend_d;
  logic        snd_pend_q, snd_pend_d;
  logic [15:0] dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic [7:0]  s_dout_q, s_dout_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        irq_n_q, irq_n_d;

  // Combinational control
  logic main_req, snd_req;
  logic main_edge, snd_edge, cmd_wr_edge, cmd_rd_edge;
  logic main_pend_eff, snd_pend_eff;
  logic snd_is_rd;
  logic main_gnt, snd_gnt;
  logic main_wr_en, snd_wr_en;
  logic [7:0] snd_byte;

  // Request edge detection, arbitration and next-state for all registers.
  // Edges are gated by RESET_N so nothing is granted (or written) while
  // reset is asserted; a strobe held through reset release still sees an edge.
  always_comb begin
    main_req      = SDBEN & (MRD | MWR);
    snd_req       = S_CS & (S_RD | S_WR);
    main_req_d    = main_req;
    snd_req_d     = snd_req;
    cmd_wr_d      = CMD_WR;
    cmd_rd_d      = S_CMD_RD;
    main_edge     = main_req & ~main_req_q & RESET_N;
    snd_edge      = snd_req & ~snd_req_q & RESET_N;
    cmd_wr_edge   = CMD_WR & ~cmd_wr_q & RESET_N;
    cmd_rd_edge   = S_CMD_RD & ~cmd_rd_q & RESET_N;
    main_pend_eff = main_pend_q | main_edge;
    snd_pend_eff  = snd_pend_q | snd_edge;
    snd_is_rd     = ~S_WR;
    main_gnt      = main_pend_eff;
    // A command read owns S_DOUT this cycle, so a sound RAM read slips one cycle.
    snd_gnt       = ~main_pend_eff & snd_pend_eff & ~(snd_is_rd & cmd_rd_edge);
    main_wr_en    = main_gnt & MWR;
    snd_wr_en     = snd_gnt & ~snd_is_rd;
    main_pend_d   = main_pend_eff & ~main_gnt;
    snd_pend_d    = snd_pend_eff & ~snd_gnt;
    snd_byte      = s_lane ? mem[s_word][15:8] : mem[s_word][7:0];

    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (main_gnt && !MWR) begin
      dout_d       = mem[m_word];
      dout_valid_d = 1'b1;
    end else if (!main_req) begin
      dout_valid_d = 1'b0;
    end

    s_dout_d = s_dout_q;
    if (cmd_rd_edge) begin
      s_dout_d = cmd_q;
    end else if (snd_gnt && snd_is_rd) begin
      s_dout_d = snd_byte;
    end

    cmd_d   = cmd_q;
    irq_n_d = irq_n_q;
    if (cmd_wr_edge) begin
      cmd_d   = DIN[7:0];
      irq_n_d = 1'b0;
    end else if (cmd_rd_edge) begin
      irq_n_d = 1'b1;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      main_req_q   <= 1'b0;
      snd_req_q    <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_rd_q     <= 1'b0;
      main_pend_q  <= 1'b0;
      snd_pend_q   <= 1'b0;
      dout_q       <= 16'h0000;
      dout_valid_q <= 1'b0;
      s_dout_q     <= 8'h00;
      cmd_q        <= 8'h00;
      irq_n_q      <= 1'b1;
    end else begin
      main_req_q   <= main_req_d;
      snd_req_q    <= snd_req_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_rd_q     <= cmd_rd_d;
      main_pend_q  <= main_pend_d;
      snd_pend_q   <= snd_pend_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      s_dout_q     <= s_dout_d;
      cmd_q        <= cmd_d;
      irq_n_q      <= irq_n_d;
    end
  end

  // Byte-lane RAM write port; main and sound grants are mutually exclusive.
  always_ff @(posedge CLK_32M) begin
    if (main_wr_en) begin
      if (BYTE_SEL[1]) mem[m_word][15:8] <= DIN[15:8];
      if (BYTE_SEL[0]) mem[m_word][7:0]  <= DIN[7:0];
    end else if (snd_wr_en) begin
      if (s_lane) mem[s_word][15:8] <= S_DIN;
      else        mem[s_word][7:0]  <= S_DIN;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign S_DOUT     = s_dout_q;
  assign S_IRQ_N    = irq_n_q;
  assign S_WAIT_N   = ~snd_pend_eff;

endmodule

// File: tb/tb_sound_shared_ram.sv
// Directed testbench for sound_shared_ram (AW=15).
module tb_sound_shared_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic [15:0] dout;
  logic        dout_valid;
  logic [19:1] a;
  logic [1:0]  bsel;
  logic        sdben, mrd, mwr, cmd_wr;
  logic [15:0] s_a;
  logic [7:0]  s_din, s_dout;
  logic        s_cs, s_rd, s_wr, s_cmd_rd, s_wait_n, s_irq_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sound_shared_ram #(.AW(15), .INIT_ZERO(1'b0)) dut (
    .CLK_32M(clk), .RESET_N(rst_n), .DIN(din), .DOUT(dout), .DOUT_VALID(dout_valid),
    .A(a), .BYTE_SEL(bsel), .SDBEN(sdben), .MRD(mrd), .MWR(mwr), .CMD_WR(cmd_wr),
    .S_A(s_a), .S_DIN(s_din), .S_DOUT(s_dout), .S_CS(s_cs), .S_RD(s_rd), .S_WR(s_wr),
    .S_CMD_RD(s_cmd_rd), .S_WAIT_N(s_wait_n), .S_IRQ_N(s_irq_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic main_write(input logic [19:1] addr, input logic [15:0] data,
                            input logic [1:0] be);
    a = addr; din = data; bsel = be; sdben = 1'b1; mwr = 1'b1;
    tick();
    mwr = 1'b0; sdben = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din = '0; a = '0; bsel = '0; sdben = 0; mrd = 0; mwr = 0; cmd_wr = 0;
    s_a = '0; s_din = '0; s_cs = 0; s_rd = 0; s_wr = 0; s_cmd_rd = 0;
    repeat (3) tick();
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL rst_dout got %h exp 0000", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid got %b exp 0", dout_valid); end
    checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL rst_s_dout got %h exp 00", s_dout); end
    checks++; if (s_wait_n !== 1'b1) begin errors++; $display("FAIL rst_s_wait_n got %b exp 1", s_wait_n); end
    checks++; if (s_irq_n !== 1'b1) begin errors++; $display("FAIL rst_s_irq_n got %b exp 1", s_irq_n); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_main_rw();
    main_write(19'h00010, 16'hBEEF, 2'b11);
    a = 19'h00010; sdben = 1'b1; mrd = 1'b1;
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL mrd_valid_grant got %b exp 0", dout_valid); end
    tick();
    checks++; if (dout !== 16'hBEEF) begin errors++; $display("FAIL mrd_data got %h exp BEEF", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL mrd_valid got %b exp 1", dout_valid); end
    tick();
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL mrd_valid_hold got %b exp 1", dout_valid); end
    mrd = 1'b0; sdben = 1'b0;
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL mrd_valid_drop got %b exp 0", dout_valid); end
    checks++; if (dout !== 16'hBEEF) begin errors++; $display("FAIL mrd_dout_hold got %h exp BEEF", dout); end
  endtask

  task automatic test_byte_lane();
    main_write(19'h00010, 16'h12AB, 2'b10);
    s_a = 16'h0021; s_cs = 1'b1; s_rd = 1'b1;
    @(negedge clk);
    checks++; if (s_wait_n !== 1'b0) begin errors++; $display("FAIL srd_wait_low got %b exp 0", s_wait_n); end
    tick();
    checks++; if (s_dout !== 8'h12) begin errors++; $display("FAIL srd_hi got %h exp 12", s_dout); end
    checks++; if (s_wait_n !== 1'b1) begin errors++; $display("FAIL srd_wait_high got %b exp 1", s_wait_n); end
    s_rd = 1'b0;
    tick();
    s_a = 16'h0020; s_rd = 1'b1;
    tick();
    checks++; if (s_dout !== 8'hEF) begin errors++; $display("FAIL srd_lo got %h exp EF", s_dout); end
    s_rd = 1'b0; s_cs = 1'b0;
    tick();
  endtask

  task automatic test_byte_sel_zero();
    main_write(19'h00010, 16'hFFFF, 2'b00);
    a = 19'h00010; sdben = 1'b1; mrd = 1'b1;
    tick();
    checks++; if (dout !== 16'h12EF) begin errors++; $display("FAIL bsel00_noop got %h exp 12EF", dout); end
    mrd = 1'b0; sdben = 1'b0;
    tick();
  endtask

  task automatic test_collision();
    a = 19'h00010; din = 16'h5678; bsel = 2'b11; sdben = 1'b1; mwr = 1'b1;
    s_a = 16'h0020; s_cs = 1'b1; s_rd = 1'b1;
    @(negedge clk);
    checks++; if (s_wait_n !== 1'b0) begin errors++; $display("FAIL coll_wait_c0 got %b exp 0", s_wait_n); end
    tick();
    checks++; if (s_wait_n !== 1'b0) begin errors++; $display("FAIL coll_wait_c1 got %b exp 0", s_wait_n); end
    checks++; if (s_dout !== 8'hEF) begin errors++; $display("FAIL coll_sdout_early got %h exp EF", s_dout); end
    tick();
    checks++; if (s_dout !== 8'h78) begin errors++; $display("FAIL coll_sdout got %h exp 78", s_dout); end
    checks++; if (s_wait_n !== 1'b1) begin errors++; $display("FAIL coll_wait_c2 got %b exp 1", s_wait_n); end
    mwr = 1'b0; sdben = 1'b0; s_rd = 1'b0; s_cs = 1'b0;
    tick();
  endtask

  task automatic test_cmd();
    din = 16'h005A; cmd_wr = 1'b1;
    tick();
    checks++; if (s_irq_n !== 1'b0) begin errors++; $display("FAIL cmd_irq_set got %b exp 0", s_irq_n); end
    cmd_wr = 1'b0; s_cmd_rd = 1'b1;
    tick();
    checks++; if (s_dout !== 8'h5A) begin errors++; $display("FAIL cmd_rd got %h exp 5A", s_dout); end
    checks++; if (s_irq_n !== 1'b1) begin errors++; $display("FAIL cmd_irq_clr got %b exp 1", s_irq_n); end
    s_cmd_rd = 1'b0;
    tick();
    din = 16'h0033; cmd_wr = 1'b1; s_cmd_rd = 1'b1;
    tick();
    checks++; if (s_dout !== 8'h5A) begin errors++; $display("FAIL cmd_coinc_dout got %h exp 5A", s_dout); end
    checks++; if (s_irq_n !== 1'b0) begin errors++; $display("FAIL cmd_coinc_irq got %b exp 0", s_irq_n); end
    cmd_wr = 1'b0; s_cmd_rd = 1'b0;
    tick();
    s_cmd_rd = 1'b1;
    tick();
    checks++; if (s_dout !== 8'h33) begin errors++; $display("FAIL cmd_new got %h exp 33", s_dout); end
    checks++; if (s_irq_n !== 1'b1) begin errors++; $display("FAIL cmd_new_irq got %b exp 1", s_irq_n); end
    s_cmd_rd = 1'b0;
    tick();
    // Command read and sound RAM read in the same cycle
    s_cmd_rd = 1'b1; s_a = 16'h0021; s_cs = 1'b1; s_rd = 1'b1;
    tick();
    checks++; if (s_dout !== 8'h33) begin errors++; $display("FAIL cmdprio_first got %h exp 33", s_dout); end
    checks++; if (s_wait_n !== 1'b0) begin errors++; $display("FAIL cmdprio_wait got %b exp 0", s_wait_n); end
    tick();
    checks++; if (s_dout !== 8'h56) begin errors++; $display("FAIL cmdprio_ram got %h exp 56", s_dout); end
    checks++; if (s_wait_n !== 1'b1) begin errors++; $display("FAIL cmdprio_wait_end got %b exp 1", s_wait_n); end
    s_cmd_rd = 1'b0; s_cs = 1'b0; s_rd = 1'b0;
    tick();
  endtask

  task automatic test_alias();
    main_write(19'h08010, 16'hCAFE, 2'b11);
    a = 19'h00010; sdben = 1'b1; mrd = 1'b1;
    tick();
    checks++; if (dout !== 16'hCAFE) begin errors++; $display("FAIL alias got %h exp CAFE", dout); end
    mrd = 1'b0; sdben = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    main_write(19'h00020, 16'h1111, 2'b11);
    a = 19'h00010; sdben = 1'b1; mrd = 1'b1;
    s_a = 16'h0040; s_din = 8'hAA; s_cs = 1'b1; s_wr = 1'b1;
    tick();
    checks++; if (dout !== 16'hCAFE) begin errors++; $display("FAIL rmid_pre_dout got %h exp CAFE", dout); end
    checks++; if (s_wait_n !== 1'b0) begin errors++; $display("FAIL rmid_pending got %b exp 0", s_wait_n); end
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL rmid_dout got %h exp 0000", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", dout_valid); end
    checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL rmid_sdout got %h exp 00", s_dout); end
    checks++; if (s_wait_n !== 1'b1) begin errors++; $display("FAIL rmid_wait got %b exp 1", s_wait_n); end
    checks++; if (s_irq_n !== 1'b1) begin errors++; $display("FAIL rmid_irq got %b exp 1", s_irq_n); end
    s_cs = 1'b0; s_wr = 1'b0;
    a = 19'h00020;  // MRD/SDBEN stay high across reset release
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rheld_valid_early got %b exp 0", dout_valid); end
    tick();
    checks++; if (dout !== 16'h1111) begin errors++; $display("FAIL rheld_dout got %h exp 1111", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL rheld_valid got %b exp 1", dout_valid); end
    a = 19'h00010;  // a second service would load CAFE
    repeat (3) tick();
    checks++; if (dout !== 16'h1111) begin errors++; $display("FAIL rheld_once got %h exp 1111", dout); end
    mrd = 1'b0; sdben = 1'b0;
    tick();
    s_a = 16'h0040; s_cs = 1'b1; s_rd = 1'b1;
    tick();
    checks++; if (s_dout !== 8'h11) begin errors++; $display("FAIL rmid_byte_kept got %h exp 11", s_dout); end
    s_rd = 1'b0; s_cs = 1'b0;
    tick();
    s_cmd_rd = 1'b1;
    tick();
    checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL rmid_cmd_cleared got %h exp 00", s_dout); end
    s_cmd_rd = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_main_rw();
    test_byte_lane();
    test_byte_sel_zero();
    test_collision();
    test_cmd();
    test_alias();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
